spi_xfer_arb: RTL and testbench

// Shares one 16-bit SPI master between the inertial interface (req 0) and the A2D interface (req 1).

---
 rtl/segway_spi_pkg.sv | 15 +
 rtl/spi_req_latch.sv | 47 ++++
 rtl/spi_xfer_arb.sv | 166 ++++++++++++++++
 tb/tb_spi_xfer_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segway_spi_pkg.sv
// Shared types and constants for the Segway SPI arbiter.
// Imported by the request latch and the arbiter top.
package segway_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } arb_state_t;

  typedef logic req_id_t;

  localparam logic [15:0] ABORT_DATA = 16'hDEAD;

endpackage

// File: rtl/spi_req_latch.sv
// One requester slot: pending flag, command capture,
// busy tracking through the done pulse, and drop detect.
module spi_req_latch
  import segway_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        grant,
  input  logic        done,
  output logic        pend,
  output logic [15:0] cmd_q,
  output logic        drop
);

  logic inflight;
  logic busy;

  assign busy = pend | inflight;
  assign drop = wrt & busy;

  // Accept a new command only when the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      cmd_q <= 16'h0000;
    end else if (wrt && !busy) begin
      pend  <= 1'b1;
      cmd_q <= cmd;
    end else if (grant) begin
      pend  <= 1'b0;
    end
  end

  // Owner stays busy from grant through its done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else if (grant) begin
      inflight <= 1'b1;
    end else if (done) begin
      inflight <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_xfer_arb.sv
// Arbiter sharing one SPI master between inertial (0)
// and A2D (1) requesters, with gap, starvation and timeout.
module spi_xfer_arb
  import segway_spi_pkg::*;
#(
  parameter int GAP_CLKS     = 8,
  parameter int STARVE_MAX   = 4,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt0,
  input  logic        wrt1,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data0,
  output logic [15:0] rd_data1,
  output logic        m_wrt,
  output logic [15:0] m_cmd,
  input  logic        m_done,
  input  logic [15:0] m_rd_data,
  input  logic        m_SS_n,
  output logic        SS0_n,
  output logic        SS1_n,
  input  logic        MISO0,
  input  logic        MISO1,
  output logic        m_MISO,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam int GW = $clog2(GAP_CLKS + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CLKS - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STARVE_MAX);

  arb_state_t    state;
  req_id_t       owner;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic [SW-1:0] starve;

  logic        pend0, pend1;
  logic [15:0] cmd0_q, cmd1_q;
  logic        drop0, drop1;
  logic        pick1, grant_go;
  logic        grant0, grant1;
  logic        timeout;

  spi_req_latch u_req0 (
    .clk   (clk),
    .rst_n (rst_n),
    .wrt   (wrt0),
    .cmd   (cmd0),
    .grant (grant0),
    .done  (done0),
    .pend  (pend0),
    .cmd_q (cmd0_q),
    .drop  (drop0)
  );

  spi_req_latch u_req1 (
    .clk   (clk),
    .rst_n (rst_n),
    .wrt   (wrt1),
    .cmd   (cmd1),
    .grant (grant1),
    .done  (done1),
    .pend  (pend1),
    .cmd_q (cmd1_q),
    .drop  (drop1)
  );

  // A2D wins when alone or once inertial has had its run.
  assign pick1    = pend1 & (~pend0 | (starve == S_MAX));
  assign grant_go = (state == IDLE) & (pend0 | pend1);
  assign grant0   = grant_go & ~pick1;
  assign grant1   = grant_go & pick1;
  assign timeout  = (state == XFER) & ~m_done
                  & (timer == T_LAST);

  assign SS0_n  = (state == XFER && owner == 1'b0)
                ? m_SS_n : 1'b1;
  assign SS1_n  = (state == XFER && owner == 1'b1)
                ? m_SS_n : 1'b1;
  assign m_MISO = owner ? MISO1 : MISO0;

  // Bus sequencer: grant, transfer, inter-frame gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      timer    <= '0;
      gap_cnt  <= '0;
      m_wrt    <= 1'b0;
      m_cmd    <= 16'h0000;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rd_data0 <= 16'h0000;
      rd_data1 <= 16'h0000;
    end else begin
      m_wrt <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_go) begin
            state <= XFER;
            owner <= pick1;
            m_wrt <= 1'b1;
            m_cmd <= pick1 ? cmd1_q : cmd0_q;
            timer <= '0;
          end
        end
        XFER: begin
          if (m_done || timeout) begin
            if (owner) begin
              rd_data1 <= m_done ? m_rd_data : ABORT_DATA;
              done1    <= 1'b1;
            end else begin
              rd_data0 <= m_done ? m_rd_data : ABORT_DATA;
              done0    <= 1'b1;
            end
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == G_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count inertial wins that happen while A2D waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (!pend1 || grant1) begin
      starve <= '0;
    end else if (grant0 && starve != S_MAX) begin
      starve <= starve + 1'b1;
    end
  end

  // Sticky fault: dropped request or aborted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (drop0 || drop1 || timeout) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_xfer_arb.sv
// Bench for spi_xfer_arb: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.
module tb_spi_xfer_arb;

  localparam int GAP     = 8;
  localparam int STARVE  = 4;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt0 = 1'b0, wrt1 = 1'b0;
  logic [15:0] cmd0 = '0, cmd1 = '0;
  logic        done0, done1;
  logic [15:0] rd_data0, rd_data1;
  logic        m_wrt;
  logic [15:0] m_cmd;
  logic        m_done = 1'b0;
  logic [15:0] m_rd_data = '0;
  logic        m_SS_n = 1'b1;
  logic        SS0_n, SS1_n;
  logic        MISO0 = 1'b0, MISO1 = 1'b0;
  logic        m_MISO;
  logic        err;

  int checks = 0;
  int failures = 0;

  spi_xfer_arb dut (
    .clk(clk), .rst_n(rst_n),
    .wrt0(wrt0), .wrt1(wrt1),
    .cmd0(cmd0), .cmd1(cmd1),
    .done0(done0), .done1(done1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .m_wrt(m_wrt), .m_cmd(m_cmd),
    .m_done(m_done), .m_rd_data(m_rd_data),
    .m_SS_n(m_SS_n),
    .SS0_n(SS0_n), .SS1_n(SS1_n),
    .MISO0(MISO0), .MISO1(MISO1),
    .m_MISO(m_MISO), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- SPI slave model ----------------
  bit          withhold = 0;
  bit          use_fixed = 1;
  logic [15:0] fix_data = 16'h1234;
  int          sl_left = 0;

  always @(posedge clk) begin
    #1;
    MISO0 = 1'($urandom);
    MISO1 = 1'($urandom);
    if (!rst_n) begin
      sl_left = 0;
      m_done  = 1'b0;
      m_SS_n  = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_wrt) begin
        m_SS_n  = 1'b0;
        sl_left = use_fixed ? 4 : $urandom_range(2, 12);
      end else if (sl_left > 0) begin
        sl_left--;
        if (sl_left == 0 && !withhold) begin
          m_done    = 1'b1;
          m_SS_n    = 1'b1;
          m_rd_data = use_fixed ? fix_data : 16'($urandom);
        end
      end
    end
  end

  // ---------------- behavioural reference ----------------
  bit          mp[2];
  logic [15:0] mc[2];
  bit          mfl[2];
  bit          xa;
  int          xo, age, gap_left, starve;
  bit          e_done[2];
  logic [15:0] e_rd[2];
  bit          e_mwrt, e_err;
  logic [15:0] e_mcmd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mp[i] = 0; mc[i] = '0; mfl[i] = 0;
        e_done[i] = 0; e_rd[i] = '0;
      end
      xa = 0; xo = 0; age = 0; gap_left = 0;
      starve = 0; e_mwrt = 0; e_err = 0; e_mcmd = '0;
    end else begin
      bit          busy[2], nd[2], w[2];
      logic [15:0] c[2];
      int          win;
      w[0] = wrt0; w[1] = wrt1;
      c[0] = cmd0; c[1] = cmd1;
      for (int i = 0; i < 2; i++) begin
        busy[i] = mp[i] | mfl[i];
        nd[i] = 0;
        if (e_done[i]) mfl[i] = 0;
      end
      win = -1;
      e_mwrt = 0;
      if (xa) begin
        if (m_done || age == TIMEOUT - 1) begin
          e_rd[xo] = m_done ? m_rd_data : 16'hDEAD;
          if (!m_done) e_err = 1;
          nd[xo] = 1;
          xa = 0;
          gap_left = GAP;
        end else begin
          age++;
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end else if (mp[0] || mp[1]) begin
        win = (mp[1] && (!mp[0] || starve == STARVE))
            ? 1 : 0;
      end
      if (!mp[1] || win == 1) starve = 0;
      else if (win == 0 && starve < STARVE) starve++;
      if (win >= 0) begin
        e_mwrt = 1;
        e_mcmd = mc[win];
        xo = win; xa = 1; age = 0;
        mfl[win] = 1;
        mp[win] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (w[i]) begin
          if (busy[i]) e_err = 1;
          else begin
            mp[i] = 1;
            mc[i] = c[i];
          end
        end
        e_done[i] = nd[i];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit ss1_low_seen = 0;
  int mw_cnt = 0;

  always @(negedge clk) begin
    logic es0, es1, emiso;
    es0 = (xa && xo == 0) ? m_SS_n : 1'b1;
    es1 = (xa && xo == 1) ? m_SS_n : 1'b1;
    emiso = (xo == 1) ? MISO1 : MISO0;
    chk("done0", 16'(done0), 16'(e_done[0]));
    chk("done1", 16'(done1), 16'(e_done[1]));
    chk("rd_data0", rd_data0, e_rd[0]);
    chk("rd_data1", rd_data1, e_rd[1]);
    chk("m_wrt", 16'(m_wrt), 16'(e_mwrt));
    chk("m_cmd", m_cmd, e_mcmd);
    chk("err", 16'(err), 16'(e_err));
    chk("SS0_n", 16'(SS0_n), 16'(es0));
    chk("SS1_n", 16'(SS1_n), 16'(es1));
    chk("m_MISO", 16'(m_MISO), 16'(emiso));
    if (SS1_n === 1'b0) ss1_low_seen = 1;
    if (m_wrt === 1'b1) mw_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return done0;
      1: return done1;
      default: return m_wrt;
    endcase
  endfunction

  task automatic wait_ev(input int which, input int budget,
                         output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (sig(which) === 1'b1) break;
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL wait_ev%0d: no event in %0d clks",
                 which, budget);
        break;
      end
    end
  endtask

  task automatic go_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n, n0;
    bit got1, reissue;
    int base;

    tick();
    tick();
    chk("rst_done0", 16'(done0), 16'h0);
    chk("rst_m_wrt", 16'(m_wrt), 16'h0);
    chk("rst_m_cmd", m_cmd, 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_ss", {SS1_n, SS0_n}, 16'h3);
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: single inertial frame with fixed slave data
    ss1_low_seen = 0;
    cmd0 = 16'hA25C;
    wrt0 = 1'b1;
    tick();
    wrt0 = 1'b0;
    chk("t1_mwrt_early", 16'(m_wrt), 16'h0);
    tick();
    chk("t1_mwrt_lat", 16'(m_wrt), 16'h1);
    chk("t1_mcmd", m_cmd, 16'hA25C);
    wait_ev(0, 100, n);
    chk("t1_rd0", rd_data0, 16'h1234);
    repeat (GAP + 4) tick();
    chk("t1_ss1_quiet", 16'(ss1_low_seen), 16'h0);

    // 2: simultaneous requests, gap between frames
    cmd0 = 16'h1111;
    cmd1 = 16'h2222;
    wrt0 = 1'b1;
    wrt1 = 1'b1;
    tick();
    wrt0 = 1'b0;
    wrt1 = 1'b0;
    tick();
    chk("t2_first", m_cmd, 16'h1111);
    wait_ev(0, 100, n);
    wait_ev(2, 100, n);
    chk("t2_gap", 16'(n), 16'(GAP + 1));
    chk("t2_second", m_cmd, 16'h2222);
    wait_ev(1, 100, n);
    repeat (GAP + 4) tick();

    // 3: inertial hogging while A2D waits
    cmd0 = 16'h0A00;
    cmd1 = 16'hB111;
    wrt0 = 1'b1;
    wrt1 = 1'b1;
    tick();
    wrt1 = 1'b0;
    wrt0 = 1'b0;
    n0 = 0;
    got1 = 0;
    reissue = 0;
    for (int i = 0; i < 3000 && !got1; i++) begin
      tick();
      wrt0 = 1'b0;
      if (m_wrt === 1'b1) begin
        if (m_cmd == 16'hB111) got1 = 1;
        else n0++;
      end
      if (reissue) begin
        cmd0 = 16'h0A00 + 16'(n0);
        wrt0 = 1'b1;
        reissue = 0;
      end
      if (done0 === 1'b1 && !got1) reissue = 1;
    end
    wrt0 = 1'b0;
    chk("t3_granted1", 16'(got1), 16'h1);
    chk("t3_req0_runs", 16'(n0), 16'(STARVE));
    repeat (100) tick();
    chk("t3_err_clear", 16'(err), 16'h0);

    // 6: reset in the middle of a frame
    cmd0 = 16'h5A5A;
    wrt0 = 1'b1;
    tick();
    wrt0 = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_ss0_pre", 16'(SS0_n), 16'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_ss", {SS1_n, SS0_n}, 16'h3);
    chk("t6_mcmd", m_cmd, 16'h0);
    chk("t6_rd0", rd_data0, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    cmd0 = 16'h6B6B;
    wrt0 = 1'b1;
    tick();
    wrt0 = 1'b0;
    tick();
    chk("t6_regrant", 16'(m_wrt), 16'h1);
    chk("t6_cmd", m_cmd, 16'h6B6B);
    wait_ev(0, 100, n);
    repeat (GAP + 4) tick();

    // 5: repeated A2D write is dropped
    base = mw_cnt;
    cmd1 = 16'hC0DE;
    wrt1 = 1'b1;
    tick();
    cmd1 = 16'hBAD1;
    tick();
    wrt1 = 1'b0;
    repeat (200) tick();
    chk("t5_frames", 16'(mw_cnt - base), 16'h1);
    chk("t5_err", 16'(err), 16'h1);
    chk("t5_rd1", rd_data1, 16'h1234);

    // 4: slave never finishes, frame is aborted
    go_reset();
    withhold = 1;
    cmd1 = 16'h7777;
    wrt1 = 1'b1;
    tick();
    wrt1 = 1'b0;
    tick();
    chk("t4_start", 16'(m_wrt), 16'h1);
    wait_ev(1, TIMEOUT + 100, n);
    chk("t4_len", 16'(n), 16'(TIMEOUT));
    chk("t4_rd1", rd_data1, 16'hDEAD);
    tick();
    chk("t4_err", 16'(err), 16'h1);
    withhold = 0;
    repeat (50) tick();
    chk("t4_err_sticky", 16'(err), 16'h1);

    // random traffic
    go_reset();
    use_fixed = 0;
    for (int i = 0; i < 4000; i++) begin
      wrt0 = ($urandom_range(0, 7) == 0);
      wrt1 = ($urandom_range(0, 7) == 0);
      cmd0 = 16'($urandom);
      cmd1 = 16'($urandom);
      tick();
    end
    wrt0 = 1'b0;
    wrt1 = 1'b0;
    repeat (100) tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
